scara_cmd_arbiter: RTL and testbench
====================================

# scara_cmd_arbiter

Shares the single nibble-wide controller command interface between two command requesters (port 0: host/UART command decoder, port 1: local path generator). It grants one requester at a time with round-robin fairness and latches its command, X and Y values. It then serializes the latched frame as a sequence of 4-bit words over a valid/ready handshake. The block sits between the command sources and the controller interface that previously received hand-set command words.

## Interface

Parameters:
- GAP_CYCLES, default 0: extra idle cycles inserted after each completed frame before the next grant (0–255).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-port request valid (bit n = port n)
- req_ready  out  2  per-port accept; combinational, at most one bit high
- req_cmd0 / req_cmd1  in  5  command code, port 0 / port 1
- req_x0 / req_x1  in  14  X value, port 0 / port 1
- req_y0 / req_y1  in  14  Y value, port 0 / port 1
- word_out  out  4  current command word to the controller interface
- word_valid  out  1  word_out is valid
- word_ready  in  1  controller interface accepts word_out
- busy  out  1  high from grant until the gap expires
- grant_id  out  1  port that owns the current or most recent frame

## Operation

- States: IDLE, SEND, GAP.
- IDLE:
  - If any req_valid bit is high, grant one port and raise req_ready for that port only.
  - Round-robin: on a tie, grant the port not equal to last_grant. With a single requester, grant it.
  - On req_valid & req_ready: latch cmd, x and y; set grant_id and last_grant; clear word index to 0; go to SEND.
- SEND:
  - word_valid = 1 and word_out = frame[idx]. word_out holds stable while word_ready is low.
  - idx increments on word_valid & word_ready.
  - After the last word is accepted: go to GAP if GAP_CYCLES > 0, otherwise go to IDLE.
- Frame order, 10 data words:
  - cmd[3:0], {3'b0,cmd[4]}
  - x[3:0], x[7:4], x[11:8], {2'b0,x[13:12]}
  - y[3:0], y[7:4], y[11:8], {2'b0,y[13:12]}
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- req_ready is 0 outside IDLE. Requests arriving during SEND or GAP wait; requesters hold req_valid and data until accepted.
- Latched values are immune to input changes after acceptance.
- Reset values:
  - state = IDLE, idx = 0, word_valid = 0, word_out = 0, busy = 0, grant_id = 0, req_ready = 0.
  - last_grant = 1, so port 0 wins the first tie.
- Reset mid-frame abandons the frame. The remaining words are never sent and no partial frame resumes.

## Timing

- Request accept to first word_valid: 1 cycle (the accept cycle is in IDLE; the next cycle is SEND).
- With word_ready tied high, a frame occupies 10 consecutive cycles (11 with checksum).
- Minimum spacing between frames is 1 IDLE cycle plus GAP_CYCLES.
- busy goes high the cycle after acceptance and falls on entry to IDLE.
- A request asserted in the same cycle the block enters IDLE is granted in that cycle.
- Simultaneous requests alternate grants frame by frame. A port requesting continuously never waits more than one frame.
- word_ready high while word_valid is low has no effect.

## Configuration

- Macro: SCARA_CMD_ARBITER_CHECKSUM_EN.
- Defined: an 11th word is appended to every frame, equal to the XOR of the 10 data words. The frame ends after this word is accepted.
- Undefined: frames are exactly 10 words and no checksum logic is built.

## Test plan

- Port 0 only, cmd=5'h13, x=14'h1234, y=14'h0ABC, word_ready=1:
  - Words 3,1,4,3,2,1,C,B,A,0 on consecutive cycles starting 1 cycle after accept.
  - With the checksum macro, an 11th word B follows.
- Both ports valid from reset: grants go 0,1,0,1 with grant_id matching. Each frame carries the respective port's data. req_ready is never high on both bits.
- word_ready low for 5 cycles on word 4:
  - word_out holds x[11:8] and word_valid stays 1.
  - The frame completes after release with no lost or duplicated word.
- GAP_CYCLES=3, port 1 held valid continuously: exactly 3 GAP cycles plus 1 IDLE cycle between the last word of one frame and the first word of the next.
- Reset asserted during word 6:
  - Next cycle word_valid=0, busy=0, state IDLE.
  - A new port 0 request afterward emits its frame from word 0.
- Port 0 changes req_x after acceptance: the emitted frame carries the originally latched x.

Source files
------------

// File: rtl/scara_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// scara_cmd_arbiter
//
// Shares the nibble-wide controller command interface between two command
// sources (port 0: host/UART decoder, port 1: local path generator). A
// round-robin arbiter grants one requester at a time, latches its command,
// X and Y values, then serializes the frame as 4-bit words over a
// valid/ready handshake:
//   cmd[3:0], {3'b0,cmd[4]},
//   x[3:0], x[7:4], x[11:8], {2'b0,x[13:12]},
//   y[3:0], y[7:4], y[11:8], {2'b0,y[13:12]}
//
// Optional feature macro: SCARA_CMD_ARBITER_CHECKSUM_EN
//   When defined, an 11th word (XOR of the 10 data words) ends every frame.
//
// Parameters:
//   GAP_CYCLES   idle cycles inserted after each frame before the next grant
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous active-high reset
//   req_valid[1:0]      per-port request valid
//   req_ready[1:0]      per-port accept (combinational, one-hot or zero)
//   req_cmd0/1[4:0]     command code per port
//   req_x0/1[13:0]      X value per port
//   req_y0/1[13:0]      Y value per port
//   word_out[3:0]       current command word
//   word_valid          word_out is valid
//   word_ready          controller interface accepts word_out
//   busy                high from the cycle after grant until return to IDLE
//   grant_id            port owning the current or most recent frame
// -----------------------------------------------------------------------------
module scara_cmd_arbiter #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [4:0]  req_cmd0,
  input  logic [4:0]  req_cmd1,
  input  logic [13:0] req_x0,
  input  logic [13:0] req_x1,
  input  logic [13:0] req_y0,
  input  logic [13:0] req_y1,
  output logic [3:0]  word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

`ifdef SCARA_CMD_ARBITER_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd10;
`else
  localparam logic [3:0] LAST_IDX = 4'd9;
`endif

  // Terminal value of the gap counter; unused when GAP_CYCLES is 0.
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

`ifdef SCARA_CMD_ARBITER_CHECKSUM_EN
  // XOR of the ten data words of a frame.
  function automatic logic [3:0] frame_checksum(input logic [4:0]  cmd,
                                                input logic [13:0] x,
                                                input logic [13:0] y);
    frame_checksum = cmd[3:0] ^ {3'b000, cmd[4]}
                   ^ x[3:0] ^ x[7:4] ^ x[11:8] ^ {2'b00, x[13:12]}
                   ^ y[3:0] ^ y[7:4] ^ y[11:8] ^ {2'b00, y[13:12]};
  endfunction
`endif

  // Selects the frame word at position idx.
  function automatic logic [3:0] frame_word(input logic [4:0]  cmd,
                                            input logic [13:0] x,
                                            input logic [13:0] y,
                                            input logic [3:0]  idx);
    case (idx)
      4'd0:    frame_word = cmd[3:0];
      4'd1:    frame_word = {3'b000, cmd[4]};
      4'd2:    frame_word = x[3:0];
      4'd3:    frame_word = x[7:4];
      4'd4:    frame_word = x[11:8];
      4'd5:    frame_word = {2'b00, x[13:12]};
      4'd6:    frame_word = y[3:0];
      4'd7:    frame_word = y[7:4];
      4'd8:    frame_word = y[11:8];
      4'd9:    frame_word = {2'b00, y[13:12]};
`ifdef SCARA_CMD_ARBITER_CHECKSUM_EN
      4'd10:   frame_word = frame_checksum(cmd, x, y);
`endif
      default: frame_word = 4'h0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [13:0] x_q, x_d;
  logic [13:0] y_q, y_d;
  logic [7:0]  gap_q, gap_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id_q, grant_id_d;
  logic [3:0]  word_out_q, word_out_d;
  logic        word_valid_q, word_valid_d;
  logic        busy_q, busy_d;
  logic        pick;

  // Arbitration, frame sequencing and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cmd_d        = cmd_q;
    x_d          = x_q;
    y_d          = y_q;
    gap_d        = gap_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    req_ready    = 2'b00;

    // On a tie the port that did not win last time is chosen.
    if (req_valid == 2'b11) begin
      pick = ~last_grant_q;
    end else begin
      pick = req_valid[1];
    end

    case (state_q)
      ST_IDLE: begin
        // Ready is only raised for a valid port, so any valid means accept.
        if (|req_valid) begin
          req_ready    = pick ? 2'b10 : 2'b01;
          cmd_d        = pick ? req_cmd1 : req_cmd0;
          x_d          = pick ? req_x1 : req_x0;
          y_d          = pick ? req_y1 : req_y0;
          grant_id_d   = pick;
          last_grant_d = pick;
          idx_d        = 4'd0;
          state_d      = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (word_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d = 4'd0;
            if (GAP_CYCLES > 0) begin
              gap_d   = 8'd0;
              state_d = ST_GAP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are precomputed from next-state values so they can be registered.
    word_valid_d = (state_d == ST_SEND);
    busy_d       = (state_d != ST_IDLE);
    if (state_d == ST_SEND) begin
      word_out_d = frame_word(cmd_d, x_d, y_d, idx_d);
    end else begin
      word_out_d = 4'h0;
    end
  end

  // State, latched frame and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      cmd_q        <= 5'd0;
      x_q          <= 14'd0;
      y_q          <= 14'd0;
      gap_q        <= 8'd0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      word_out_q   <= 4'h0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cmd_q        <= cmd_d;
      x_q          <= x_d;
      y_q          <= y_d;
      gap_q        <= gap_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_scara_cmd_arbiter.sv
module tb_scara_cmd_arbiter;

`ifdef SCARA_CMD_ARBITER_CHECKSUM_EN
  localparam int NW = 11;
`else
  localparam int NW = 10;
`endif

  // Frames packed with word i at bits [4*i+3:4*i].
  // A: cmd=13 x=1234 y=0ABC -> 3,1,4,3,2,1,C,B,A,0 (+B)
  // B: cmd=0A x=2DEF y=1357 -> A,0,F,E,D,2,7,5,3,1 (+4)
  localparam logic [43:0] FA = 44'hB0ABC123413;
  localparam logic [43:0] FB = 44'h413572DEF0A;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [4:0]  req_cmd0, req_cmd1;
  logic [13:0] req_x0, req_x1, req_y0, req_y1;
  logic [3:0]  word_out;
  logic        word_valid, word_ready, busy, grant_id;

  logic [1:0]  rv3, rr3;
  logic [3:0]  wo3;
  logic        wv3, wr3, busy3, gid3;

  int total = 0;
  int bad   = 0;

  scara_cmd_arbiter #(.GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1), .req_x0(req_x0), .req_x1(req_x1),
    .req_y0(req_y0), .req_y1(req_y1), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy), .grant_id(grant_id)
  );

  scara_cmd_arbiter #(.GAP_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rr3),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1), .req_x0(req_x0), .req_x1(req_x1),
    .req_y0(req_y0), .req_y1(req_y1), .word_out(wo3), .word_valid(wv3),
    .word_ready(wr3), .busy(busy3), .grant_id(gid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_p0(input logic [4:0] c, input logic [13:0] x, input logic [13:0] y);
    req_cmd0 = c; req_x0 = x; req_y0 = y;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    rv3 = 2'b00;
    tick();
    tick();
    total++;
    if ({word_valid, word_out, busy, grant_id, req_ready} !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs: got wv=%0b wo=%h busy=%0b gid=%0b rdy=%b, want all 0",
               word_valid, word_out, busy, grant_id, req_ready);
    end
    total++;
    if ({wv3, busy3} !== 2'b00) begin
      bad++;
      $display("FAIL reset_gapdut: got wv=%0b busy=%0b, want 0 0", wv3, busy3);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [43:0] f;
    f = FA;
    set_p0(5'h13, 14'h1234, 14'h0ABC);
    req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL single_ready: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    total++;
    if ({busy, grant_id} !== 2'b10) begin
      bad++;
      $display("FAIL single_busy_gid: got busy=%0b gid=%0b want 1 0", busy, grant_id);
    end
    for (int i = 0; i < NW; i++) begin
      total++;
      if ({word_valid, word_out} !== {1'b1, f[i*4 +: 4]}) begin
        bad++;
        $display("FAIL single_word%0d: got v=%0b w=%h want v=1 w=%h", i, word_valid, word_out, f[i*4 +: 4]);
      end
      tick();
    end
    total++;
    if ({word_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_end: got wv=%0b busy=%0b want 0 0", word_valid, busy);
    end
  endtask

  task automatic test_latch();
    logic [43:0] f;
    f = FA;
    set_p0(5'h13, 14'h1234, 14'h0ABC);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    set_p0(5'h00, 14'h3FFF, 14'h0000);
    for (int i = 0; i < NW; i++) begin
      total++;
      if ({word_valid, word_out} !== {1'b1, f[i*4 +: 4]}) begin
        bad++;
        $display("FAIL latch_word%0d: got v=%0b w=%h want v=1 w=%h", i, word_valid, word_out, f[i*4 +: 4]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [43:0] f;
    f = FA;
    set_p0(5'h13, 14'h1234, 14'h0ABC);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < NW; i++) begin
      if (i == 4) begin
        word_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          total++;
          if ({word_valid, word_out} !== {1'b1, 4'h2}) begin
            bad++;
            $display("FAIL stall_hold%0d: got v=%0b w=%h want v=1 w=2", s, word_valid, word_out);
          end
          tick();
        end
        word_ready = 1'b1;
      end
      total++;
      if ({word_valid, word_out} !== {1'b1, f[i*4 +: 4]}) begin
        bad++;
        $display("FAIL stall_word%0d: got v=%0b w=%h want v=1 w=%h", i, word_valid, word_out, f[i*4 +: 4]);
      end
      tick();
    end
    total++;
    if (word_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_end: got wv=%0b want 0", word_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [43:0] f;
    logic        exp_port;
    int          n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_p0(5'h13, 14'h1234, 14'h0ABC);
    req_cmd1 = 5'h0A; req_x1 = 14'h2DEF; req_y1 = 14'h1357;
    req_valid = 2'b11;
    for (int fr = 0; fr < 4; fr++) begin
      exp_port = (fr % 2 == 1);
      f = exp_port ? FB : FA;
      #1;
      n = 0;
      while (req_ready === 2'b00 && n < 20) begin
        tick();
        #1;
        n++;
      end
      total++;
      if (req_ready !== (exp_port ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL b2b_grant%0d: got ready=%b want port %0d (waited %0d)", fr, req_ready, exp_port, n);
      end
      tick();
      total++;
      if (grant_id !== exp_port) begin
        bad++;
        $display("FAIL b2b_gid%0d: got %0b want %0b", fr, grant_id, exp_port);
      end
      for (int i = 0; i < NW; i++) begin
        total++;
        if ({word_valid, word_out, req_ready} !== {1'b1, f[i*4 +: 4], 2'b00}) begin
          bad++;
          $display("FAIL b2b_f%0d_w%0d: got v=%0b w=%h rdy=%b want v=1 w=%h rdy=00",
                   fr, i, word_valid, word_out, req_ready, f[i*4 +: 4]);
        end
        tick();
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [43:0] f;
    f = FB;
    set_p0(5'h13, 14'h1234, 14'h0ABC);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (6) tick();
    total++;
    if ({word_valid, word_out} !== {1'b1, 4'hC}) begin
      bad++;
      $display("FAIL rmid_word6: got v=%0b w=%h want v=1 w=c", word_valid, word_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({word_valid, busy, req_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL rmid_after: got wv=%0b busy=%0b rdy=%b want 0 0 00", word_valid, busy, req_ready);
    end
    set_p0(5'h0A, 14'h2DEF, 14'h1357);
    req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL rmid_ready: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < NW; i++) begin
      total++;
      if ({word_valid, word_out} !== {1'b1, f[i*4 +: 4]}) begin
        bad++;
        $display("FAIL rmid_word%0d: got v=%0b w=%h want v=1 w=%h", i, word_valid, word_out, f[i*4 +: 4]);
      end
      tick();
    end
  endtask

  task automatic test_gap();
    logic [43:0] f;
    logic [3:0]  busy_exp;
    f = FB;
    busy_exp = 4'b0111;   // index k: busy in k-th idle cycle after last word
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_cmd1 = 5'h0A; req_x1 = 14'h2DEF; req_y1 = 14'h1357;
    rv3 = 2'b10;
    #1;
    total++;
    if (rr3 !== 2'b10) begin
      bad++;
      $display("FAIL gap_ready: got %b want 10", rr3);
    end
    tick();
    for (int i = 0; i < NW; i++) begin
      total++;
      if ({wv3, wo3} !== {1'b1, f[i*4 +: 4]}) begin
        bad++;
        $display("FAIL gap_word%0d: got v=%0b w=%h want v=1 w=%h", i, wv3, wo3, f[i*4 +: 4]);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if ({wv3, busy3, rr3} !== {1'b0, busy_exp[k], (k == 3) ? 2'b10 : 2'b00}) begin
        bad++;
        $display("FAIL gap_idle%0d: got wv=%0b busy=%0b rdy=%b want wv=0 busy=%0b", k, wv3, busy3, rr3, busy_exp[k]);
      end
      tick();
    end
    total++;
    if ({wv3, wo3, gid3} !== {1'b1, 4'hA, 1'b1}) begin
      bad++;
      $display("FAIL gap_next_first: got v=%0b w=%h gid=%0b want v=1 w=a gid=1", wv3, wo3, gid3);
    end
    rv3 = 2'b00;
    repeat (NW + 6) tick();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    rv3 = 2'b00;
    word_ready = 1'b1;
    wr3 = 1'b1;
    set_p0(5'h00, 14'h0000, 14'h0000);
    req_cmd1 = 5'h00; req_x1 = 14'h0000; req_y1 = 14'h0000;
    test_reset();
    test_single();
    test_latch();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
